// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/busy/done handshake, operands and result of the iterative multiplier
interface seq_multiplier_if #(parameter int N = 4) ();
  logic start;
  logic sgn;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic busy;
  logic done;
  logic [2*N-1:0] p;
  logic ovf;
  modport master (output start, sgn, a, b, input busy, done, p, ovf);
  modport slave (input start, sgn, a, b, output busy, done, p, ovf);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier retiring one multiplier bit per cycle, signed or unsigned
module seq_multiplier #(parameter int N = 4) (
  input logic clk,
  input logic rst_n,
  seq_multiplier_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [2*N-1:0] mcand, acc, acc_nxt, res;
  logic [N-1:0] mplier, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic neg, sgn_r, last, ovf_nxt;
  // operand magnitudes, next accumulator, signed fix-up of the final sum and its overflow test
  always_comb begin
    mag_a = (bus.sgn && bus.a[N-1]) ? -bus.a : bus.a;
    mag_b = (bus.sgn && bus.b[N-1]) ? -bus.b : bus.b;
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    res = neg ? -acc_nxt : acc_nxt;
    last = cnt == CW'(N - 1);
    ovf_nxt = sgn_r ? !((&res[2*N-1:N-1]) || !(|res[2*N-1:N-1])) : |res[2*N-1:N];
    state_nxt = (state == IDLE) ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  assign bus.busy = state == RUN;
  // state register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // capture on accepted start, one add/shift per RUN cycle, publish result on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
      sgn_r <= 1'b0;
      bus.p <= '0;
      bus.ovf <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE && bus.start) begin
        mcand <= {{N{1'b0}}, mag_a};
        mplier <= mag_b;
        acc <= '0;
        cnt <= '0;
        neg <= bus.sgn & (bus.a[N-1] ^ bus.b[N-1]);
        sgn_r <= bus.sgn;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + CW'(1);
        if (last) begin
          bus.p <= res;
          bus.ovf <= ovf_nxt;
          bus.done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier for the ALU datapath. It generalises the combinational N=4 multiplier to any width N and adds a signed/unsigned mode. It also adds a start/busy/done handshake and an N-bit overflow flag. One operand bit is retired per cycle, so area stays constant as N grows; the ALU controller issues operations and waits on done.

Parameters:
N, 4, operand width in bits; product width is 2*N; legal range 2..32
CW, $clog2(N)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
sgn  input  1  1 = two's-complement operands/result, 0 = unsigned; captured with start
a  input  N  multiplicand; captured with start
b  input  N  multiplier; captured with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse, result valid
p  output  2*N  product; holds last result until next done
ovf  output  1  product does not fit in N bits in the selected mode; valid with p

Behaviour:
- Reset (rst_n low, async): state=IDLE, busy=0, done=0, p=0, ovf=0, internal registers cleared. Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: busy=0. If start=1 at edge k, capture operands, go to RUN, busy=1 from edge k.
  - RUN: one iteration per edge at edges k+1..k+N. At edge k+N, move the final result into p, pulse done=1 for that cycle, set busy=0, and return to IDLE.
- Latency: done is high in the cycle after edge k+N, which is N cycles after the start edge. Throughput is one operation per N+1 cycles.
- Back-to-back: start held high is re-sampled in IDLE the cycle after done.
- Operand conditioning at capture:
  - sgn=1: magnitudes |a| and |b| are formed as N-bit unsigned values; the most-negative value -2^(N-1) maps to 2^(N-1) without error. neg = a[N-1]^b[N-1] is recorded.
  - sgn=0: operands are used as-is; neg=0.
- Iteration: a 2N-bit accumulator adds the shifted multiplicand when the current multiplier LSB is 1. The multiplicand shifts left and the multiplier shifts right each cycle. The counter counts N iterations.
- Result: p = neg ? -(acc) : acc, computed modulo 2^(2N) and registered at the final edge.
- ovf, registered with p:
  - sgn=0: 1 if p[2N-1:N] != 0.
  - sgn=1: 1 if p[2N-1:N-1] is not all-0 or all-1.
- A start asserted while busy=1 is ignored; it is not queued and operands are not re-captured.
- Operand inputs may change freely after the start edge; they do not affect the result.
- done never asserts without a preceding accepted start. p and ovf change only on done edges or reset.
- A zero operand still takes the full N iterations (fixed latency); the result is p=0, ovf=0.

Test Plan:
1. N=4, sgn=0, a=3, b=6, start one cycle -> busy=1 for 4 cycles; done pulses exactly 4 cycles after the start edge; p=8'd18, ovf=1. Separately, a=2, b=3 -> p=8'd6, ovf=0.
2. N=4, sgn=0, a=9, b=9 -> p=8'd81 (8'h51), ovf=1. Then a=0, b=0 -> p=8'h00, ovf=0, same 4-cycle latency.
3. N=4, sgn=1, a=5, b=4'hF (-1) -> p=8'hFB (-5), ovf=0. Then a=4'hB (-5), b=1 -> p=8'hFB, ovf=0.
4. N=4, sgn=1, a=4'h8 (-8), b=4'h8 (-8) -> p=8'h40 (64), ovf=1. Then a=4'h8, b=7 -> p=8'hC8 (-56), ovf=1.
5. Start a=3, b=6; assert start again with a=15, b=15 during busy -> second request ignored; single done with p=18. Start held high after done -> new operation begins the next cycle.
6. Assert rst_n low two cycles into an operation -> busy, done, p and ovf go to 0 immediately (async). After release, no done appears until a new start; a fresh a=7, b=7 unsigned -> p=8'd49, ovf=1.
